// File: rtl/arb_rr4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// The optional hold-timeout feature is enabled with the ARB_TIMEOUT_EN macro.
package arb_rr4_pkg;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} arb_state_e;
  typedef logic [NREQ-1:0] req_vec_t;

  function automatic req_vec_t id_to_onehot(input logic [ID_W-1:0] id);
    req_vec_t v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/arb_rr4_ctrl_if.sv
// Request/grant bundle between the arbiter (slave) and the requester side (master).
// Handshake: req is a level held until service completes; gnt is a registered one-hot ownership flag.
interface arb_rr4_ctrl_if;
  import arb_rr4_pkg::*;

  req_vec_t        req;
  req_vec_t        gnt;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_vld;
  logic            any_req;
  logic            no_req;
  logic            preempt;

  modport master (
    output req,
    input  gnt, gnt_id, gnt_vld, any_req, no_req, preempt
  );

  modport slave (
    input  req,
    output gnt, gnt_id, gnt_vld, any_req, no_req, preempt
  );
endinterface

// File: rtl/rr_pick4.sv
// Combinational rotating priority picker: first set bit of (req & ~mask) searching base, base+1, ...
module rr_pick4
  import arb_rr4_pkg::*;
(
  input  req_vec_t        req,
  input  logic [ID_W-1:0] base,
  input  req_vec_t        mask,
  output logic            found,
  output logic [ID_W-1:0] win_id
);
  req_vec_t eff;

  always_comb begin
    logic [ID_W-1:0] idx;
    eff    = req & ~mask;
    found  = 1'b0;
    win_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = base + ID_W'(i);
      if (eff[idx] && !found) begin
        found  = 1'b1;
        win_id = idx;
      end
    end
  end
endmodule

// File: rtl/arb_rr4_ctrl.sv
// Round-robin arbiter with locked one-hot grants among 4 requesters.
// Define ARB_TIMEOUT_EN to bound each lock to HOLD_MAX cycles when a competitor waits.
module arb_rr4_ctrl
  import arb_rr4_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  arb_rr4_ctrl_if.slave bus,
  output arb_state_e    dbg_state
);
  arb_state_e      state_q, state_d;
  req_vec_t        gnt_q, gnt_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            preempt_q, preempt_d;

  logic            found;
  logic [ID_W-1:0] win_id;
  logic            owner_req;
  logic            do_grant;
  logic            do_free;
  logic            any_req;

  // Masking with the current grant excludes the owner on release and on preemption.
  rr_pick4 u_pick (
    .req    (bus.req),
    .base   (ptr_q),
    .mask   (gnt_q),
    .found  (found),
    .win_id (win_id)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    preempt_d = 1'b0;
    do_grant  = 1'b0;
    do_free   = 1'b0;
    owner_req = |(bus.req & gnt_q);
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (found) do_grant = 1'b1;
      end
      OWNED: begin
        if (!owner_req) begin
          if (found) do_grant = 1'b1;
          else       do_free  = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        // Counter saturates at the limit so a late competitor preempts immediately.
        else if (hold_cnt_q == HOLD_LAST) begin
          if (found) begin
            do_grant  = 1'b1;
            preempt_d = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
`endif
      end
      default: do_free = 1'b1;
    endcase

    if (do_grant) begin
      gnt_d    = id_to_onehot(win_id);
      gnt_id_d = win_id;
      ptr_d    = win_id + ID_W'(1);
      state_d  = OWNED;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d = '0;
`endif
    end else if (do_free) begin
      gnt_d    = '0;
      gnt_id_d = '0;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      preempt_q <= preempt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_cnt_q <= '0;
    else          hold_cnt_q <= hold_cnt_d;
  end
`endif

  assign any_req     = |bus.req;
  assign bus.any_req = any_req;
  assign bus.no_req  = ~any_req;
  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gnt_vld = |gnt_q;
  assign bus.preempt = preempt_q;
  assign dbg_state   = state_q;

  a_hold_max_legal: assert property (@(posedge clk) disable iff (!reset_n)
    (HOLD_MAX >= 2) && (HOLD_MAX <= 255));
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(gnt_q));
endmodule

// File: tb/tb_arb_rr4_ctrl.sv
// Scoreboard bench for arb_rr4_ctrl: directed request vectors with hand-computed grants.
// Build with ARB_TIMEOUT_EN to exercise preemption (HOLD_MAX=4) instead of the unbounded lock.
module tb_arb_rr4_ctrl;
  import arb_rr4_pkg::*;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TB_HOLD_MAX = 4;
`else
  localparam int unsigned TB_HOLD_MAX = 8;
`endif
  localparam int EXP_W = 11;

  logic       clk;
  logic       reset_n;
  arb_state_e dbg_state;

  arb_rr4_ctrl_if bus ();

  arb_rr4_ctrl #(.HOLD_MAX(TB_HOLD_MAX)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_step = 0;

  // {preempt, any_req, no_req, gnt_vld, gnt_id, gnt, owned}
  function automatic logic [EXP_W-1:0] make_exp(input logic [3:0] r, input logic [3:0] g,
                                                input logic p);
    logic [1:0] id;
    case (g)
      4'b0010: id = 2'd1;
      4'b0100: id = 2'd2;
      4'b1000: id = 2'd3;
      default: id = 2'd0;
    endcase
    return {p, |r, ~|r, g != 4'b0000, id, g, g != 4'b0000};
  endfunction

  // driver: apply req (and reset level) at negedge; expected state after next posedge
  task automatic drv(input logic [3:0] r, input logic [3:0] g, input logic p, input logic rn);
    @(negedge clk);
    reset_n = rn;
    bus.req = r;
    exp_q.push_back(make_exp(r, g, p));
  endtask

  // monitor: outputs are presented every cycle, compare 1 time unit after the edge
  initial begin
    logic [EXP_W-1:0] act, exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act = {bus.preempt, bus.any_req, bus.no_req, bus.gnt_vld, bus.gnt_id, bus.gnt,
               dbg_state == OWNED};
        n_step++;
        n_cmp++;
        if (act !== exp_v) begin
          n_err++;
          $display("FAIL step%0d {pre,any,no,vld,id,gnt,own}: got %b required %b",
                   n_step, act, exp_v);
        end
      end
    end
  end

  initial begin
    int drain;
    reset_n = 1'b0;
    bus.req = 4'b0000;

    // reset with all requests active: no grant, summaries live
    drv(4'b1111, 4'b0000, 1'b0, 1'b0);
    drv(4'b1111, 4'b0000, 1'b0, 1'b0);
    drv(4'b1111, 4'b0001, 1'b0, 1'b1);

    // round robin: each owner drops for one cycle
    drv(4'b1110, 4'b0010, 1'b0, 1'b1);
    drv(4'b1101, 4'b0100, 1'b0, 1'b1);
    drv(4'b1011, 4'b1000, 1'b0, 1'b1);
    drv(4'b0111, 4'b0001, 1'b0, 1'b1);
    drv(4'b1111, 4'b0001, 1'b0, 1'b1);
    drv(4'b1100, 4'b0100, 1'b0, 1'b1);

`ifndef ARB_TIMEOUT_EN
    // unbounded lock on requester 2
    for (int i = 0; i < 20; i++) drv(4'b1111, 4'b0100, 1'b0, 1'b1);
`endif

    // owner 1 with ptr=2, then release while 3 and 0 rise
    drv(4'b0010, 4'b0010, 1'b0, 1'b1);
    drv(4'b0010, 4'b0010, 1'b0, 1'b1);
    drv(4'b1001, 4'b1000, 1'b0, 1'b1);

    // idle then single requester
    drv(4'b0000, 4'b0000, 1'b0, 1'b1);
    drv(4'b0000, 4'b0000, 1'b0, 1'b1);
    drv(4'b0010, 4'b0010, 1'b0, 1'b1);

`ifdef ARB_TIMEOUT_EN
    drv(4'b0000, 4'b0000, 1'b0, 1'b1);
    drv(4'b0011, 4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drv(4'b0011, 4'b0001, 1'b0, 1'b1);
    drv(4'b0011, 4'b0010, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drv(4'b0011, 4'b0010, 1'b0, 1'b1);
    drv(4'b0011, 4'b0001, 1'b1, 1'b1);
    drv(4'b0000, 4'b0000, 1'b0, 1'b1);
    // saturation: lone owner well past the limit, competitor preempts at once
    for (int i = 0; i < 6; i++) drv(4'b0001, 4'b0001, 1'b0, 1'b1);
    drv(4'b0011, 4'b0010, 1'b1, 1'b1);
    drv(4'b0000, 4'b0000, 1'b0, 1'b1);
`endif

    // asynchronous reset mid-grant drops the grant without waiting for an edge
    drv(4'b1111, 4'b0000, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b0000 || bus.gnt_vld !== 1'b0 || bus.gnt_id !== 2'd0) begin
      n_err++;
      $display("FAIL async_reset: got gnt=%b vld=%b id=%0d required gnt=0000 vld=0 id=0",
               bus.gnt, bus.gnt_vld, bus.gnt_id);
    end
    drv(4'b1111, 4'b0001, 1'b0, 1'b1);
    drv(4'b0000, 4'b0000, 1'b0, 1'b1);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
